// File: rtl/gate_resp_misr.sv
// -----------------------------------------------------------------------------
// gate_resp_misr
// Response compactor for the 21-input/10-output gate-library netlist. Each
// accepted response vector is folded into a multiple-input signature register.
// After NUM_PAT patterns the signature is compared with GOLDEN and the result
// is held until the next start or abort.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst         in   synchronous active-high reset
//   start       in   begin a run (honoured in IDLE and DONE only)
//   abort       in   cancel a run, return to IDLE (beats start and accept)
//   resp        in   RESP_W response vector (N195..N221, MSB-first)
//   resp_mask   in   RESP_W bit mask, 0 = bit ignored (GATE_RESP_MISR_MASK_EN only)
//   resp_valid  in   resp carries a pattern
//   resp_ready  out  block accepts resp this cycle
//   busy        out  run in progress (RUN or CHECK)
//   done        out  run finished, pass valid
//   pass        out  final signature == GOLDEN
//   signature   out  current MISR contents
//   pat_count   out  patterns accepted in current/last run
//
// Build option: define GATE_RESP_MISR_MASK_EN to add the resp_mask input so
// X-prone response bits can be excluded from the signature.
// -----------------------------------------------------------------------------
module gate_resp_misr #(
   parameter int               RESP_W  = 10,
   parameter int               SIG_W   = 16,
   parameter logic [SIG_W-1:0] POLY    = 16'h1021,
   parameter logic [SIG_W-1:0] SEED    = 16'h0000,
   parameter int               NUM_PAT = 256,
   parameter logic [SIG_W-1:0] GOLDEN  = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [RESP_W-1:0] resp,
`ifdef GATE_RESP_MISR_MASK_EN
   input  logic [RESP_W-1:0] resp_mask,
`endif
   input  logic              resp_valid,
   output logic              resp_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature,
   output logic [15:0]       pat_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // pat_count value just before the final accept of a run
   localparam logic [15:0] LAST_CNT = 16'(NUM_PAT - 1);

   state_t            state_q, state_d;
   logic [SIG_W-1:0]  sig_q, sig_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              pass_q, pass_d;

   logic [RESP_W-1:0] resp_eff;
   logic [SIG_W-1:0]  fold_sig;
   logic              accept;

`ifdef GATE_RESP_MISR_MASK_EN
   assign resp_eff = resp & resp_mask;
`else
   assign resp_eff = resp;
`endif

   // One MISR step per bit: shift left, XOR the feedback taps when the MSB
   // falls out, and fold in the response on the low RESP_W bits.
   genvar gi;
   generate
      for (gi = 0; gi < SIG_W; gi++) begin : g_fold
         logic shift_bit;
         logic in_bit;
         if (gi == 0) begin : g_lsb
            assign shift_bit = 1'b0;
         end else begin : g_mid
            assign shift_bit = sig_q[gi-1];
         end
         if (gi < RESP_W) begin : g_in
            assign in_bit = resp_eff[gi];
         end else begin : g_zero
            assign in_bit = 1'b0;
         end
         assign fold_sig[gi] = shift_bit ^ (sig_q[SIG_W-1] & POLY[gi]) ^ in_bit;
      end
   endgenerate

   // Handshake outputs decode the state register only, so resp_ready has
   // no combinational dependence on resp_valid.
   assign resp_ready = (state_q == RUN);
   assign busy       = (state_q == RUN) || (state_q == CHECK);
   assign done       = (state_q == DONE);
   assign pass       = pass_q;
   assign signature  = sig_q;
   assign pat_count  = cnt_q;

   assign accept = resp_valid && resp_ready && !abort;

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      if (abort) begin
         // signature and count are left intact for post-mortem inspection
         state_d = IDLE;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sig_d   = SEED;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  sig_d = fold_sig;
                  cnt_d = cnt_q + 16'd1;
                  if (cnt_q == LAST_CNT) begin
                     state_d = CHECK;
                  end
               end
            end
            CHECK: begin
               pass_d  = (sig_q == GOLDEN);
               state_d = DONE;
            end
            DONE: begin
               if (start) begin
                  sig_d   = SEED;
                  cnt_d   = '0;
                  pass_d  = 1'b0;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

endmodule

// File: tb/tb_gate_resp_misr.sv
// -----------------------------------------------------------------------------
// tb_gate_resp_misr
// Self-checking bench for gate_resp_misr. Instance A (SEED=0, NUM_PAT=4,
// GOLDEN=16'h1FF8) is driven through a scoreboard: the expected signature and
// count are queued as each pattern is driven and popped when the accept is
// observed. Instances B (SEED=FFFF, NUM_PAT=1, GOLDEN=0) and C (SEED=0,
// NUM_PAT=1, GOLDEN=1) share inputs and cover the single-pattern cases.
// -----------------------------------------------------------------------------
module tb_gate_resp_misr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A
   logic        start_a = 1'b0, abort_a = 1'b0, valid_a = 1'b0;
   logic [9:0]  resp_a = '0, mask_a = '1;
   logic        ready_a, busy_a, done_a, pass_a;
   logic [15:0] sig_a, cnt_a;

   // instances B and C
   logic        start_bc = 1'b0, abort_bc = 1'b0, valid_bc = 1'b0;
   logic [9:0]  resp_bc = '0, mask_bc = '1;
   logic        ready_b, busy_b, done_b, pass_b;
   logic [15:0] sig_b, cnt_b;
   logic        ready_c, busy_c, done_c, pass_c;
   logic [15:0] sig_c, cnt_c;

   gate_resp_misr #(.RESP_W(10), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000),
                    .NUM_PAT(4), .GOLDEN(16'h1FF8)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .resp(resp_a),
`ifdef GATE_RESP_MISR_MASK_EN
      .resp_mask(mask_a),
`endif
      .resp_valid(valid_a), .resp_ready(ready_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .signature(sig_a), .pat_count(cnt_a));

   gate_resp_misr #(.RESP_W(10), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF),
                    .NUM_PAT(1), .GOLDEN(16'h0000)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_bc), .abort(abort_bc), .resp(resp_bc),
`ifdef GATE_RESP_MISR_MASK_EN
      .resp_mask(mask_bc),
`endif
      .resp_valid(valid_bc), .resp_ready(ready_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .signature(sig_b), .pat_count(cnt_b));

   gate_resp_misr #(.RESP_W(10), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000),
                    .NUM_PAT(1), .GOLDEN(16'h0001)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_bc), .abort(abort_bc), .resp(resp_bc),
`ifdef GATE_RESP_MISR_MASK_EN
      .resp_mask(mask_bc),
`endif
      .resp_valid(valid_bc), .resp_ready(ready_c), .busy(busy_c), .done(done_c),
      .pass(pass_c), .signature(sig_c), .pat_count(cnt_c));

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference MISR step for x^16+x^12+x^5+1
   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] r);
      logic [15:0] n;
      n = {s[14:0], 1'b0};
      if (s[15]) n = n ^ 16'h1021;
      n = n ^ {6'b0, r};
      return n;
   endfunction

   typedef struct {
      logic [15:0] sig;
      logic [15:0] cnt;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [15:0] m_sig = '0;
   logic [15:0] m_cnt = '0;

   // Scoreboard side: every observed accept on A must match a queued entry.
   always @(posedge clk) begin
      if (!rst && valid_a && ready_a && !abort_a) begin
         @(negedge clk);
         chk("acc_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("acc_sig", 32'(sig_a), 32'(mon_e.sig));
            chk("acc_cnt", 32'(cnt_a), 32'(mon_e.cnt));
            $display("accept A: sig=%h cnt=%0d", sig_a, cnt_a);
         end
      end
   end

   // All tasks are entered and left at a falling edge.
   task automatic start_run_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      m_sig = 16'h0000;
      m_cnt = 16'd0;
   endtask

   task automatic drive_a(input logic [9:0] r);
      valid_a = 1'b1;
      resp_a  = r;
      m_sig   = misr_step(m_sig, r & mask_a);
      m_cnt   = m_cnt + 16'd1;
      exp_q.push_back('{sig: m_sig, cnt: m_cnt});
      @(negedge clk);
      valid_a = 1'b0;
   endtask

   task automatic wait_done_a();
      int n = 0;
      while (!done_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_a_wait", 32'(done_a), 1);
   endtask

   task automatic wait_done_bc();
      int n = 0;
      while (!(done_b && done_c) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_bc_wait", 32'({done_b, done_c}), 32'b11);
   endtask

   task automatic run_bc(input logic [9:0] r);
      start_bc = 1'b1;
      @(negedge clk);
      start_bc = 1'b0;
      valid_bc = 1'b1;
      resp_bc  = r;
      @(negedge clk);
      valid_bc = 1'b0;
      wait_done_bc();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_ready", 32'(ready_a), 0);
      chk("rst_busy",  32'(busy_a),  0);
      chk("rst_done",  32'(done_a),  0);
      chk("rst_pass",  32'(pass_a),  0);
      chk("rst_sig_a", 32'(sig_a),   0);
      chk("rst_cnt_a", 32'(cnt_a),   0);
      chk("rst_sig_b", 32'(sig_b),   32'hFFFF);

      // run 1: known sequence, back-to-back accepts, exact done latency
      start_run_a();
      chk("run_busy",  32'(busy_a),  1);
      chk("run_ready", 32'(ready_a), 1);
      drive_a(10'h3FF);
      drive_a(10'h000);
      drive_a(10'h000);
      drive_a(10'h000);
      chk("check_ready", 32'(ready_a), 0);
      chk("check_busy",  32'(busy_a),  1);
      chk("check_done",  32'(done_a),  0);
      @(negedge clk);
      chk("r1_done", 32'(done_a), 1);
      chk("r1_pass", 32'(pass_a), 1);
      chk("r1_busy", 32'(busy_a), 0);
      chk("r1_sig",  32'(sig_a),  32'h1FF8);
      chk("r1_cnt",  32'(cnt_a),  4);
      $display("run1 A: sig=%h pass=%0d", sig_a, pass_a);

      // run 2: restart from DONE, resp_valid toggling
      start_run_a();
      chk("r2_done_clr", 32'(done_a), 0);
      chk("r2_pass_clr", 32'(pass_a), 0);
      chk("r2_seed",     32'(sig_a),  0);
      chk("r2_cnt_clr",  32'(cnt_a),  0);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) drive_a(10'($urandom));
         else @(negedge clk);
      end
      wait_done_a();
      chk("r2_cnt",  32'(cnt_a),  4);
      chk("r2_sig",  32'(sig_a),  32'(m_sig));
      chk("r2_pass", 32'(pass_a), 32'(m_sig == 16'h1FF8));
      $display("run2 A: sig=%h pass=%0d", sig_a, pass_a);

      // resp_valid held in DONE must not be accepted
      valid_a = 1'b1;
      resp_a  = 10'h3FF;
      repeat (3) @(negedge clk);
      valid_a = 1'b0;
      chk("done_hold_cnt",  32'(cnt_a),  4);
      chk("done_hold_sig",  32'(sig_a),  32'(m_sig));
      chk("done_hold_done", 32'(done_a), 1);

      // run 3: abort after 3 accepts
      start_run_a();
      drive_a(10'h011);
      drive_a(10'h022);
      drive_a(10'h233);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_busy",  32'(busy_a),  0);
      chk("abort_ready", 32'(ready_a), 0);
      chk("abort_done",  32'(done_a),  0);
      chk("abort_cnt",   32'(cnt_a),   3);
      chk("abort_sig",   32'(sig_a),   32'(m_sig));
      $display("abort A: sig=%h cnt=%0d", sig_a, cnt_a);

      // resp_valid in IDLE ignored; abort beats start
      valid_a = 1'b1;
      repeat (3) @(negedge clk);
      valid_a = 1'b0;
      chk("idle_hold_cnt", 32'(cnt_a), 3);
      start_a = 1'b1;
      abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      chk("abort_prio_busy", 32'(busy_a), 0);

      // run 4: clean run after abort
      start_run_a();
      chk("r4_seed", 32'(sig_a), 0);
      drive_a(10'h3FF);
      drive_a(10'h000);
      drive_a(10'h000);
      drive_a(10'h000);
      wait_done_a();
      chk("r4_pass", 32'(pass_a), 1);
      chk("r4_sig",  32'(sig_a),  32'h1FF8);
      $display("run4 A: sig=%h pass=%0d", sig_a, pass_a);

      // abort in DONE clears done/pass, keeps signature
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_d_done", 32'(done_a), 0);
      chk("abort_d_pass", 32'(pass_a), 0);
      chk("abort_d_sig",  32'(sig_a),  32'h1FF8);

`ifdef GATE_RESP_MISR_MASK_EN
      // fully masked responses leave the signature at SEED
      mask_a = 10'h000;
      start_run_a();
      drive_a(10'h3FF);
      chk("mask_sig1", 32'(sig_a), 0);
      drive_a(10'h3FF);
      drive_a(10'h3FF);
      drive_a(10'h3FF);
      wait_done_a();
      chk("mask_sig", 32'(sig_a), 0);
      mask_a = 10'h3FF;
`endif

      // reset mid-run restores reset values
      start_run_a();
      drive_a(10'h155);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 32'(busy_a), 0);
      chk("mrst_sig",  32'(sig_a),  0);
      chk("mrst_cnt",  32'(cnt_a),  0);

      // B/C single-pattern runs
      run_bc(10'h001);
      chk("c1_sig",  32'(sig_c),  32'h0001);
      chk("c1_pass", 32'(pass_c), 1);
      chk("c1_cnt",  32'(cnt_c),  1);
      chk("b1_sig",  32'(sig_b),  32'hEFDE);
      chk("b1_pass", 32'(pass_b), 0);
      $display("run BC resp=001: sig_b=%h sig_c=%h pass_c=%0d", sig_b, sig_c, pass_c);
      run_bc(10'h000);
      chk("b2_sig",  32'(sig_b),  32'hEFDF);
      chk("b2_pass", 32'(pass_b), 0);
      chk("b2_done", 32'(done_b), 1);
      chk("c2_sig",  32'(sig_c),  0);
      chk("c2_pass", 32'(pass_c), 0);
      $display("run BC resp=000: sig_b=%h sig_c=%h pass_b=%0d", sig_b, sig_c, pass_b);

      @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
